tx_ffe_emu: RTL and testbench

// Parametrised FPGA emulation model of the transmitter and channel. It convolves the transmitted

---
 rtl/tx_ffe_emu.sv | 173 +++++++++++++++++
 tb/tb_tx_ffe_emu.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ffe_emu.sv
// tx_ffe_emu: transmitter + channel emulation. Convolves a PAM2/PAM4 symbol
// stream with a run-time programmable impulse response (shadow/active banks).
// The pipeline has two register stages: the products, then the narrowed sum.
// Build macro: TX_EMU_SATURATE_EN makes an overflowing output clamp to the
// OUT_W signed range. Without it the output wraps (two's-complement truncation).

// One tap: coefficient times a level in {-3,-1,+1,+3}, built from shift/add.
module tx_ffe_emu_tap #(
  parameter int COEF_W = 16
) (
  input  logic              vld_i,
  input  logic [2:0]        lvl_i,
  input  logic [COEF_W-1:0] coef_i,
  output logic [COEF_W+1:0] prod_o
);
  localparam int P_W = COEF_W + 2;

  logic [P_W-1:0] c_ext;
  logic [P_W-1:0] mag;
  logic           is3;

  // Scale by 1 or 3, then negate for negative levels. Invalid history entries give 0.
  always_comb begin
    c_ext  = {{2{coef_i[COEF_W-1]}}, coef_i};
    is3    = (lvl_i == 3'b011) || (lvl_i == 3'b101);
    mag    = is3 ? ((c_ext << 1) + c_ext) : c_ext;
    prod_o = '0;
    if (vld_i) prod_o = lvl_i[2] ? -mag : mag;
  end
endmodule

module tx_ffe_emu #(
  parameter int N_TAPS = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 18,
  parameter int SHIFT  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      sym_valid_i,
  input  logic [1:0]                sym_i,
  input  logic                      pam4_i,
  input  logic                      cfg_we_i,
  input  logic [$clog2(N_TAPS)-1:0] cfg_addr_i,
  input  logic [COEF_W-1:0]         cfg_data_i,
  input  logic                      cfg_commit_i,
  output logic                      cfg_busy_o,
  output logic                      out_valid_o,
  output logic [OUT_W-1:0]          out_value_o,
  output logic                      ovf_o
);
  localparam int AW  = $clog2(N_TAPS);
  localparam int P_W = COEF_W + 2;
  localparam int S_W = P_W + AW;

  logic [N_TAPS-1:0][COEF_W-1:0] shadow_q, active_q;
  logic                          busy_q;
  logic                          commit_ok, wr_ok;

  logic [N_TAPS-1:0][2:0]        hlvl_q, hlvl_d;
  logic [N_TAPS-1:0]             hvld_q, hvld_d;
  logic [2:0]                    lvl_new;

  logic [N_TAPS-1:0][P_W-1:0]    prod_d, prod_q;
  logic [1:0]                    vld_pipe_q;

  logic signed [S_W-1:0]         sum, shifted;
  logic                          ovf_now;
  logic [OUT_W-1:0]              narrow;
  logic [OUT_W-1:0]              out_q;
  logic                          ovf_q;

  // Commits and writes are both locked out for the busy cycle after a commit.
  assign commit_ok = cfg_commit_i && !busy_q;
  assign wr_ok     = cfg_we_i && !busy_q && ({1'b0, cfg_addr_i} < (AW+1)'(N_TAPS));

  // Map the incoming symbol to a 3-bit signed level (PAM4 is Gray coded).
  always_comb begin
    lvl_new = sym_i[0] ? 3'b011 : 3'b101;
    if (pam4_i) begin
      case (sym_i)
        2'b00:   lvl_new = 3'b101;  // -3
        2'b01:   lvl_new = 3'b111;  // -1
        2'b11:   lvl_new = 3'b001;  // +1
        default: lvl_new = 3'b011;  // +3
      endcase
    end
  end

  // Next history: index 0 is the newest symbol and the oldest one drops off the end.
  always_comb begin
    hlvl_d = hlvl_q;
    hvld_d = hvld_q;
    if (sym_valid_i) begin
      hlvl_d = {hlvl_q[N_TAPS-2:0], lvl_new};
      hvld_d = {hvld_q[N_TAPS-2:0], 1'b1};
    end
  end

  // Products come from the updated history and the bank that is active before any same-edge commit.
  for (genvar i = 0; i < N_TAPS; i++) begin : g_tap
    tx_ffe_emu_tap #(.COEF_W(COEF_W)) u_tap (
      .vld_i  (hvld_d[i]),
      .lvl_i  (hlvl_d[i]),
      .coef_i (active_q[i]),
      .prod_o (prod_d[i])
    );
  end

  // Full-precision sum, arithmetic shift, then narrowing with overflow detection.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_TAPS; i++)
      sum = sum + {{AW{prod_q[i][P_W-1]}}, prod_q[i]};
    shifted = sum >>> SHIFT;
    // The value fits when every bit above the OUT_W sign bit repeats that sign bit.
    ovf_now = !((&shifted[S_W-1:OUT_W-1]) || !(|shifted[S_W-1:OUT_W-1]));
`ifdef TX_EMU_SATURATE_EN
    if (ovf_now)
      narrow = shifted[S_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    else
      narrow = shifted[OUT_W-1:0];
`else
    narrow = shifted[OUT_W-1:0];
`endif
  end

  // Coefficient banks: the commit copies the shadow first, so a same-edge write stays in the shadow only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      active_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      if (commit_ok) active_q <= shadow_q;
      if (wr_ok)     shadow_q[cfg_addr_i] <= cfg_data_i;
      busy_q <= commit_ok;
    end
  end

  // Symbol history and stage-1 products advance only when a symbol arrives.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hlvl_q     <= '0;
      hvld_q     <= '0;
      prod_q     <= '0;
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], sym_valid_i};
      if (sym_valid_i) begin
        hlvl_q <= hlvl_d;
        hvld_q <= hvld_d;
        prod_q <= prod_d;
      end
    end
  end

  // Stage 2: register the output sample and keep the overflow flag sticky.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else if (vld_pipe_q[0]) begin
      out_q <= narrow;
      if (ovf_now) ovf_q <= 1'b1;
    end
  end

  assign cfg_busy_o  = busy_q;
  assign out_valid_o = vld_pipe_q[1];
  assign out_value_o = out_q;
  assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_tx_ffe_emu.sv
// Self-checking bench for tx_ffe_emu: a behavioural model feeds a scoreboard
// queue at drive time, and a monitor compares every out_valid_o sample.
// Direct checks cover latency, the level map table and the multi-cycle corner cases.
module tb_tx_ffe_emu;
  localparam int N_TAPS = 16;
  localparam int COEF_W = 16;
  localparam int OUT_W  = 18;
  localparam int SHIFT  = 2;
  localparam int AW     = $clog2(N_TAPS);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sym_valid_i = 1'b0;
  logic [1:0]        sym_i = '0;
  logic              pam4_i = 1'b0;
  logic              cfg_we_i = 1'b0;
  logic [AW-1:0]     cfg_addr_i = '0;
  logic [COEF_W-1:0] cfg_data_i = '0;
  logic              cfg_commit_i = 1'b0;
  logic              cfg_busy_o, out_valid_o, ovf_o;
  logic [OUT_W-1:0]  out_value_o;

  tx_ffe_emu #(.N_TAPS(N_TAPS), .COEF_W(COEF_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sym_valid_i  (sym_valid_i),
    .sym_i        (sym_i),
    .pam4_i       (pam4_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_data_i   (cfg_data_i),
    .cfg_commit_i (cfg_commit_i),
    .cfg_busy_o   (cfg_busy_o),
    .out_valid_o  (out_valid_o),
    .out_value_o  (out_value_o),
    .ovf_o        (ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct { longint val; bit ovf; } exp_t;
  typedef struct { logic [1:0] s; bit p; longint exp; } vec_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  int     n_cmp = 0;
  int     n_err = 0;

  longint m_shadow[N_TAPS];
  longint m_active[N_TAPS];
  int     m_lvl[N_TAPS];
  bit     m_vld[N_TAPS];
  bit     m_busy, m_ovf;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lvl_of(input logic [1:0] s, input bit p);
    if (!p) return s[0] ? 3 : -3;
    case (s)
      2'b00:   return -3;
      2'b01:   return -1;
      2'b11:   return 1;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_TAPS; i++) begin
      m_shadow[i] = 0; m_active[i] = 0; m_lvl[i] = 0; m_vld[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // Expected output for the current model history and active bank.
  task automatic push_expected();
    longint sum, sh, hi, lo, w;
    exp_t   e;
    sum = 0;
    for (int i = 0; i < N_TAPS; i++)
      if (m_vld[i]) sum += m_active[i] * m_lvl[i];
    sh = sum >>> SHIFT;
    hi = (longint'(1) <<< (OUT_W-1)) - 1;
    lo = -(longint'(1) <<< (OUT_W-1));
    if (sh > hi || sh < lo) begin
      m_ovf = 1'b1;
`ifdef TX_EMU_SATURATE_EN
      w = (sh > hi) ? hi : lo;
`else
      w = sh & ((longint'(1) <<< OUT_W) - 1);
      if (w > hi) w -= (longint'(1) <<< OUT_W);
`endif
    end else begin
      w = sh;
    end
    e.val = w;
    e.ovf = m_ovf;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of inputs, apply the model's edge semantics, then step to 1 ns past the edge.
  task automatic cyc(input bit sv, input logic [1:0] s, input bit p,
                     input bit we, input int addr, input longint data, input bit commit);
    bit c_ok, w_ok;
    sym_valid_i  = sv;
    sym_i        = s;
    pam4_i       = p;
    cfg_we_i     = we;
    cfg_addr_i   = addr[AW-1:0];
    cfg_data_i   = data[COEF_W-1:0];
    cfg_commit_i = commit;
    if (sv) begin
      for (int i = N_TAPS-1; i > 0; i--) begin
        m_lvl[i] = m_lvl[i-1];
        m_vld[i] = m_vld[i-1];
      end
      m_lvl[0] = lvl_of(s, p);
      m_vld[0] = 1'b1;
      push_expected();
    end
    c_ok = commit && !m_busy;
    w_ok = we && !m_busy && (addr < N_TAPS);
    if (c_ok) for (int i = 0; i < N_TAPS; i++) m_active[i] = m_shadow[i];
    if (w_ok) m_shadow[addr] = longint'($signed(data[COEF_W-1:0]));
    m_busy = c_ok;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic wr(input int addr, input longint data);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, addr, data, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sym_valid_i = 1'b0; cfg_we_i = 1'b0; cfg_commit_i = 1'b0;
    model_reset();
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb_q.size() != 0 && budget < 10) begin
      idle();
      budget++;
    end
    if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 0);
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (!rst && out_valid_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_value", longint'($signed(out_value_o)), mon_e.val);
        check("sb_ovf", longint'(ovf_o), longint'(mon_e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[6];

  initial begin
    tbl[0] = '{2'b00, 1'b1, -3};
    tbl[1] = '{2'b01, 1'b1, -1};
    tbl[2] = '{2'b11, 1'b1,  1};
    tbl[3] = '{2'b10, 1'b1,  3};
    tbl[4] = '{2'b10, 1'b0, -3};
    tbl[5] = '{2'b01, 1'b0,  3};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_value", longint'($signed(out_value_o)), 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_busy", cfg_busy_o, 0);
    rst = 1'b0;

    // Latency and start-up: coef[0]=4, a single PAM4 '10' gives 3 at n+2 only.
    wr(0, 4);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 1'b1);
    check("busy_after_commit", cfg_busy_o, 1);
    idle();
    check("busy_clears", cfg_busy_o, 0);
    cyc(1'b1, 2'b10, 1'b1, 1'b0, 0, 0, 1'b0);
    check("lat_n1_valid", out_valid_o, 0);
    idle();
    check("lat_n2_valid", out_valid_o, 1);
    check("lat_n2_value", longint'($signed(out_value_o)), 3);
    idle();
    check("lat_n3_valid", out_valid_o, 0);
    check("hold_value", longint'($signed(out_value_o)), 3);

    // Level map table: only tap 0 is non-zero, so the output equals the level.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, tbl[i].s, tbl[i].p, 1'b0, 0, 0, 1'b0);
      idle();
      check($sformatf("map_valid_%0d", i), out_valid_o, 1);
      check($sformatf("map_value_%0d", i), longint'($signed(out_value_o)), tbl[i].exp);
    end
    drain();

    // Impulse: coef 100/50, PAM2 symbols 1,0,0.
    do_reset();
    wr(0, 100);
    wr(1, 50);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 1'b1);
    idle();
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 0, 0, 1'b0);
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0);
    check("impulse_first", longint'($signed(out_value_o)), 75);
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0);
    drain();

    // Commit race with continuous PAM4 streaming.
    do_reset();
    wr(0, 8);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 1'b1);
    idle();
    wr(0, 16);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b0, 0, 0, 1'b0);
    cyc(1'b1, 2'b10, 1'b1, 1'b1, 1, 7, 1'b1);     // symbol k + commit + same-cycle write
    check("race_busy", cfg_busy_o, 1);
    cyc(1'b1, 2'b10, 1'b1, 1'b1, 0, 99, 1'b1);    // dropped write and ignored commit
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b0, 0, 0, 1'b0);
    cyc(1'b1, 2'b10, 1'b1, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b0, 0, 0, 1'b0);
    drain();

    // Mode switch: PAM4 11 then PAM2 1, coef[0]=coef[1]=4.
    do_reset();
    wr(0, 4);
    wr(1, 4);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 1'b1);
    idle();
    cyc(1'b1, 2'b11, 1'b1, 1'b0, 0, 0, 1'b0);
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 0, 0, 1'b0);
    idle();
    check("mode_second", longint'($signed(out_value_o)), 4);
    drain();

    // Overflow: every tap at full scale, PAM4 +3 symbols.
    do_reset();
    for (int i = 0; i < N_TAPS; i++) wr(i, 32767);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 1'b1);
    idle();
    for (int i = 0; i < 20; i++) cyc(1'b1, 2'b10, 1'b1, 1'b0, 0, 0, 1'b0);
    idle();
`ifdef TX_EMU_SATURATE_EN
    check("ovf_value", longint'($signed(out_value_o)), 131071);
`else
    check("ovf_value", longint'($signed(out_value_o)), 131060);
`endif
    check("ovf_set", ovf_o, 1);
    drain();
    repeat (3) idle();
    check("ovf_sticky", ovf_o, 1);

    // Reset mid-stream with two samples in flight.
    cyc(1'b1, 2'b10, 1'b1, 1'b0, 0, 0, 1'b0);
    cyc(1'b1, 2'b10, 1'b1, 1'b0, 0, 0, 1'b0);
    rst = 1'b1;
    sym_valid_i = 1'b0;
    model_reset();
    sb_q.delete();
    #1;
    check("midrst_valid", out_valid_o, 0);
    check("midrst_ovf", ovf_o, 0);
    check("midrst_value", longint'($signed(out_value_o)), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle();
      check($sformatf("midrst_no_pulse_%0d", i), out_valid_o, 0);
    end
    cyc(1'b1, 2'b10, 1'b1, 1'b0, 0, 0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
